// File: rtl/y_mux4to1.sv
// y_mux4to1: SIZE-bit 4:1 word mux (two-level 2:1 tree) with optional capture stage (macro YMUX4TO1_REG_OUT_EN).
// Latency: z is combinational (0 cycles); z_q/c_q/vld_q register 1 cycle after an en edge, else pass-through.
// Backpressure: none; en simply holds the capture registers, the combinational path is never stalled.
module y_mux4to1 #(
  parameter int SIZE = 2
) (
  output logic [SIZE-1:0] z,
  input  logic [SIZE-1:0] a0,
  input  logic [SIZE-1:0] a1,
  input  logic [SIZE-1:0] a2,
  input  logic [SIZE-1:0] a3,
  input  logic [1:0]      c,
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  output logic [SIZE-1:0] z_q,
  output logic [1:0]      c_q,
  output logic            vld_q
);

  logic [SIZE-1:0] s0_mask;
  logic [SIZE-1:0] s1_mask;
  logic [SIZE-1:0] lvl1_lo;
  logic [SIZE-1:0] lvl1_hi;

  // Gate-level AND/OR form so an X/Z select propagates rather than defaulting to one input.
  assign s0_mask = {SIZE{c[0]}};
  assign s1_mask = {SIZE{c[1]}};
  assign lvl1_lo = (a0 & ~s0_mask) | (a1 & s0_mask);
  assign lvl1_hi = (a2 & ~s0_mask) | (a3 & s0_mask);
  assign z       = (lvl1_lo & ~s1_mask) | (lvl1_hi & s1_mask);

`ifdef YMUX4TO1_REG_OUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q   <= '0;
      c_q   <= 2'b00;
      vld_q <= 1'b0;
    end else if (en) begin
      z_q   <= z;
      c_q   <= c;
      vld_q <= 1'b1;
    end
  end
`else
  // Flop-free build: the "captured" outputs mirror the live path.
  logic unused_clk_en;
  assign unused_clk_en = &{1'b0, clk, en};
  assign z_q   = z;
  assign c_q   = c;
  assign vld_q = rst_n;
`endif

endmodule

// File: tb/tb_y_mux4to1.sv
// Scoreboard bench for y_mux4to1: stimulus pushes expected values, a monitor pops and compares on each sample strobe.
module tb_y_mux4to1;

  localparam int K_Z32 = 0, K_ZQ32 = 1, K_CQ32 = 2, K_VQ32 = 3;
  localparam int K_Z8 = 4, K_ZQ8 = 5, K_VQ8 = 6, K_CQ8 = 7, K_Z1 = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, en;
  logic [31:0] a0, a1, a2, a3, z, zq;
  logic [1:0]  c, cq;
  logic        vq;
  logic [7:0]  b0, b1, b2, b3, y, yq;
  logic [1:0]  d, dq;
  logic        yv;
  logic        s0, s1, s2, s3, sz, szq;
  logic [1:0]  e, eq;
  logic        sv;

  y_mux4to1 #(.SIZE(32)) dut32 (.z(z), .a0(a0), .a1(a1), .a2(a2), .a3(a3), .c(c), .clk(clk),
    .rst_n(rst_n), .en(en), .z_q(zq), .c_q(cq), .vld_q(vq));
  y_mux4to1 #(.SIZE(8)) dut8 (.z(y), .a0(b0), .a1(b1), .a2(b2), .a3(b3), .c(d), .clk(clk),
    .rst_n(rst_n), .en(en), .z_q(yq), .c_q(dq), .vld_q(yv));
  y_mux4to1 #(.SIZE(1)) dut1 (.z(sz), .a0(s0), .a1(s1), .a2(s2), .a3(s3), .c(e), .clk(clk),
    .rst_n(rst_n), .en(en), .z_q(szq), .c_q(eq), .vld_q(sv));

  typedef struct {
    string       nm;
    int          kind;
    logic [31:0] exp;
  } exp_t;

  exp_t sbq[$];
  event smp;
  int   errors = 0;
  int   checks = 0;

  function automatic logic [31:0] actual(int k);
    case (k)
      K_Z32:   return z;
      K_ZQ32:  return zq;
      K_CQ32:  return {30'b0, cq};
      K_VQ32:  return {31'b0, vq};
      K_Z8:    return {24'b0, y};
      K_ZQ8:   return {24'b0, yq};
      K_VQ8:   return {31'b0, yv};
      K_CQ8:   return {30'b0, dq};
      default: return {31'b0, sz};
    endcase
  endfunction

  task automatic push(input string nm, input int k, input logic [31:0] ex);
    sbq.push_back('{nm, k, ex});
  endtask

  task automatic sample();
    -> smp;
    #1;
  endtask

  initial begin
    forever begin
      @(smp);
      while (sbq.size() > 0) begin
        exp_t t;
        logic [31:0] act;
        t = sbq.pop_front();
        act = actual(t.kind);
        checks++;
        if (act !== t.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h", t.nm, act, t.exp);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: bench did not complete within time limit");
    $fatal(1, "timeout");
  end

  logic [31:0] dir_a [4];
  logic [31:0] r;

  initial begin
    dir_a[0] = 32'h12153524; dir_a[1] = 32'hC0895E81;
    dir_a[2] = 32'h8484D609; dir_a[3] = 32'hB1F05663;
    rst_n = 1'b0; en = 1'b0;
    a0 = dir_a[0]; a1 = dir_a[1]; a2 = dir_a[2]; a3 = dir_a[3]; c = 2'b00;
    b0 = 8'h00; b1 = 8'h00; b2 = 8'h00; b3 = 8'h00; d = 2'b00;
    s0 = 1'b0; s1 = 1'b0; s2 = 1'b0; s3 = 1'b0; e = 2'b00;
    #2;
    push("reset_vld_q", K_VQ32, 32'd0);
`ifdef YMUX4TO1_REG_OUT_EN
    push("reset_z_q", K_ZQ32, 32'd0);
    push("reset_c_q", K_CQ32, 32'd0);
`else
    push("reset_z_q_pass", K_ZQ32, 32'h12153524);
`endif
    sample();
    @(negedge clk);
    rst_n = 1'b1;

    // Directed sweep of the select.
    for (int i = 0; i < 4; i++) begin
      c = 2'(i);
      #1;
      push($sformatf("dir_z_c%0d", i), K_Z32, dir_a[i]);
      sample();
    end

    // Random vectors against the reference expression.
    for (int i = 0; i < 10; i++) begin
      a0 = $urandom; a1 = $urandom; a2 = $urandom; a3 = $urandom;
      c = 2'($urandom_range(3));
      #1;
      r = (c == 0) ? a0 : (c == 1) ? a1 : (c == 2) ? a2 : a3;
      push($sformatf("rand_z_%0d", i), K_Z32, r);
      sample();
    end

    // SIZE=1 sweep: only a3 is one.
    s3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      e = 2'(i);
      #1;
      push($sformatf("size1_z_c%0d", i), K_Z1, (i == 3) ? 32'd1 : 32'd0);
      sample();
    end

    // SIZE=8 select of a1.
    b1 = 8'hA5; d = 2'b01;
    #1;
    push("size8_z", K_Z8, 32'h000000A5);
`ifndef YMUX4TO1_REG_OUT_EN
    push("size8_z_q_noclk", K_ZQ8, 32'h000000A5);
    push("size8_c_q_noclk", K_CQ8, 32'd1);
    push("size8_vld_q_rst1", K_VQ8, 32'd1);
`endif
    sample();

`ifdef YMUX4TO1_REG_OUT_EN
    // No capture while en is low.
    @(negedge clk);
    a2 = 32'hDEADBEEF; c = 2'b10; en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    push("noen_vld_q", K_VQ32, 32'd0);
    push("noen_z_q", K_ZQ32, 32'd0);
    sample();
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1;
    push("cap_z_q", K_ZQ32, 32'hDEADBEEF);
    push("cap_c_q", K_CQ32, 32'd2);
    push("cap_vld_q", K_VQ32, 32'd1);
    sample();
    @(negedge clk);
    en = 1'b0; a2 = 32'h0; c = 2'b01;
    repeat (3) @(posedge clk);
    #1;
    push("hold_z_q", K_ZQ32, 32'hDEADBEEF);
    push("hold_c_q", K_CQ32, 32'd2);
    push("hold_vld_q", K_VQ32, 32'd1);
    sample();
    // Asynchronous reset between edges.
    @(negedge clk);
    a2 = 32'h13579BDF; c = 2'b10;
    #2;
    rst_n = 1'b0;
    #1;
    push("arst_z_q", K_ZQ32, 32'd0);
    push("arst_c_q", K_CQ32, 32'd0);
    push("arst_vld_q", K_VQ32, 32'd0);
    push("arst_z_live", K_Z32, 32'h13579BDF);
    sample();
    @(negedge clk);
    rst_n = 1'b1; a3 = 32'hCAFEF00D; c = 2'b11; en = 1'b1;
    @(posedge clk);
    #1;
    push("recap_z_q", K_ZQ32, 32'hCAFEF00D);
    push("recap_c_q", K_CQ32, 32'd3);
    push("recap_vld_q", K_VQ32, 32'd1);
    sample();
    en = 1'b0;
`else
    // Pass-through build: outputs follow inputs with no clock.
    a2 = 32'hDEADBEEF; c = 2'b10; en = 1'b1;
    #1;
    push("pass_z_q", K_ZQ32, 32'hDEADBEEF);
    push("pass_c_q", K_CQ32, 32'd2);
    push("pass_vld_q", K_VQ32, 32'd1);
    sample();
    en = 1'b0; a2 = 32'h0;
    #1;
    push("pass_z_q_follow", K_ZQ32, 32'd0);
    sample();
    a2 = 32'h13579BDF;
    rst_n = 1'b0;
    #1;
    push("pass_vld_q_rst0", K_VQ32, 32'd0);
    push("pass_vld8_rst0", K_VQ8, 32'd0);
    push("pass_z_live_rst0", K_Z32, 32'h13579BDF);
    push("pass_z8_q_rst0", K_ZQ8, 32'h000000A5);
    sample();
    rst_n = 1'b1;
`endif

    #2;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/y_mux4to1.md
# y_mux4to1

Parameterized 4-to-1 word multiplexer for the datapath: selects one of four SIZE-bit inputs by a 2-bit select and presents it combinationally on `z` with zero cycles of latency. It is the building block behind register-file read ports and ALU result selection. It also carries a clocked capture stage. The stage holds the selected word and the select used, for pipelined consumers.

## Interface
- `SIZE`, default 2: data width in bits; legal range is 1 to 64.
- `clk`, input, 1 bit: clock. All state updates on the rising edge.
- `rst_n`, input, 1 bit: reset, asynchronous, active-low.
- `z`, output, SIZE bits: combinational selected word.
- `a0`, input, SIZE bits: data, selected when `c`=00.
- `a1`, input, SIZE bits: data, selected when `c`=01.
- `a2`, input, SIZE bits: data, selected when `c`=10.
- `a3`, input, SIZE bits: data, selected when `c`=11.
- `c`, input, 2 bits: select.
- `en`, input, 1 bit: capture enable for the clocked stage.
- `z_q`, output, SIZE bits: captured selected word.
- `c_q`, output, 2 bits: select value captured with `z_q`.
- `vld_q`, output, 1 bit: high once at least one capture has occurred since reset.
- Declaration order is `z, a0, a1, a2, a3, c, clk, rst_n, en, z_q, c_q, vld_q`.
  - Legacy 6-port positional instantiations therefore bind the combinational path correctly.
  - In such instantiations `en`, `clk` and `rst_n` are unconnected.
  - Unconnected inputs are tolerated; the combinational path never depends on them.

## Operation
- `z` is selected by `c`: 00 gives `a0`, 01 gives `a1`, 10 gives `a2`, 11 gives `a3`.
- Structure is a two-level tree of SIZE-wide 2:1 muxes.
  - Level 1: `c[0]` picks between `a0`/`a1` and between `a2`/`a3`.
  - Level 2: `c[1]` picks between the two level-1 results.
- Each 2:1 mux computes `out = (a & ~s) | (b & s)` per bit.
- No arithmetic, no width extension; every path is exactly SIZE bits.
- X/Z on `c` propagates per gate semantics. It is not resolved to a default input.
- Clocked stage, on a rising edge of `clk` with `en`=1:
  - `z_q` takes the current `z`.
  - `c_q` takes `c`.
  - `vld_q` goes to 1.
- With `en`=0, all three registers hold their values.
- `vld_q` is sticky and clears only on reset.

## Timing
- `z` is purely combinational: 0 cycles of latency, valid after gate settle (two 2:1 levels).
- `z_q`/`c_q`/`vld_q` have 1-cycle latency: they reflect the inputs sampled at the enabling edge.
- Reset (`rst_n`=0) takes effect immediately, asynchronously: `z_q`=0, `c_q`=00, `vld_q`=0.
- Release of `rst_n` is synchronized by the consumer. The first capture happens at the first enabled edge with `rst_n`=1.
- Reset asserted mid-operation: registers clear immediately, and `z` keeps following its inputs.
- Simultaneous input change and edge: the values present at the edge (setup-satisfied) are captured.

## Configuration
- Macro: `YMUX4TO1_REG_OUT_EN`.
- Defined: the clocked stage is implemented as described above.
- Not defined: no flops are instantiated.
  - `z_q` = `z` and `c_q` = `c`, combinationally.
  - `vld_q` = `rst_n`.
  - `clk` and `en` are ignored.

## Test plan
- SIZE=32, `a0`=0x12153524, `a1`=0xC0895E81, `a2`=0x8484D609, `a3`=0xB1F05663. Step `c` through 00,01,10,11, checking 1 time unit after each change.
  - Required: `z` equals `a0`, `a1`, `a2`, `a3` in turn, compared with `===`.
- Run 10 random vectors for `a0`–`a3` and `c`; compare against the reference expression `c==0?a0:c==1?a1:c==2?a2:a3`.
  - Required: every vector matches.
- Reg stage (macro defined), SIZE=32, `c`=10, `a2`=0xDEADBEEF, `en`=1, one rising edge.
  - Required: `z_q`=0xDEADBEEF, `c_q`=10, `vld_q`=1.
  - Then set `en`=0 and change `a2` to 0.
  - Required: `z_q` still 0xDEADBEEF after 3 edges.
- Assert `rst_n`=0 between edges after a capture.
  - Required: `z_q`=0, `c_q`=00, `vld_q`=0 immediately, with no clock edge.
  - Required: `z` still tracks the selected input.
- Macro undefined, SIZE=8, `a1`=0xA5, `c`=01.
  - Required: `z_q`=0xA5 with no clock applied; `vld_q` follows `rst_n`.
- SIZE=1, all-ones `a3`, all others 0, sweep `c`.
  - Required: `z`=1 only for `c`=11.
